encoder83_scan: RTL and testbench
=================================

# encoder83_scan

- Serialising 8-to-3 encoder: the inverse of the team's 3-to-8 one-hot/one-cold decoder.
- Accepts a multi-hot (or multi-cold) request vector through a valid/ready handshake.
- Emits the encoded index of every set bit, lowest first, one per output handshake, with a last marker.
- Sits between status/interrupt vectors and index-driven consumers (register-file select, decoder inputs).

## Interface

- WIDTH, 8: request vector width; must be a power of two and at least 2.
- IDX_W, $clog2(WIDTH) (localparam, 3 at default): index width.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inValid  in  1  dataIn/polIn offered.
- inReady  out  1  block idle and able to capture a vector.
- dataIn  in  WIDTH  request vector.
- polIn  in  1  0: dataIn is one-hot style (bit=1 active); 1: one-cold style (bit=0 active).
- outValid  out  1  idxOut/lastOut valid.
- outReady  in  1  consumer accepts the current index.
- idxOut  out  IDX_W  index of lowest pending active bit.
- lastOut  out  1  idxOut is the final pending bit of the current vector.
- remain  out  IDX_W+1  count of pending bits, including the one currently presented.
- emptyErr  out  1  one-cycle pulse: an accepted vector had no active bits.

## Operation

- State register, two states:
  - IDLE: inReady=1, outValid=0.
  - SCAN: inReady=0, outValid=1.
- Capture in IDLE when inValid&&inReady:
  - Compute v = polIn ? ~dataIn : dataIn.
  - If v==0: pulse emptyErr and stay in IDLE.
  - Otherwise: load pend=v and go to SCAN.
- In SCAN, idxOut, lastOut and remain are derived only from pend, via the lowest-set-bit encoder and a popcount.
  - lastOut = (remain==1).
- Beat: outValid&&outReady in SCAN.
  - Clear the lowest set bit of pend.
  - If lastOut was 1, go to IDLE.
- Backpressure: with outReady=0, pend, idxOut, lastOut and remain hold stable indefinitely.
- inValid is ignored in SCAN; there is no overlap of vectors.
- The upstream producer holds dataIn/polIn stable while inValid&&!inReady.
- Reset values: state=IDLE, pend=0, outValid=0, idxOut=0, lastOut=0, remain=0, emptyErr=0, inReady=1.
- Reset mid-scan discards all pending bits; nothing is replayed after release.
- X/Z on dataIn with inValid=0 has no effect.

## Timing

- Capture at edge N: outValid=1 with the first index during cycle N+1 (latency 1).
- Throughput is one index per cycle while outReady=1.
  - A vector with k active bits occupies SCAN for k cycles minimum.
- The last beat at edge M gives inReady=1 in cycle M+1.
  - The earliest next capture is edge M+1, a one-cycle bubble between vectors.
- emptyErr is registered: high exactly in cycle N+1 after the capture edge N; inReady stays 1 throughout.
- Reset assertion clears outputs asynchronously, without waiting for a clock edge.
- Deassertion is synchronised externally; the first capture is possible on the first edge after release.
- No combinational path from inValid/dataIn/outReady to any output.
  - inReady and outValid are decoded from the state register only.

## Structure

- Package encoder_pkg holds:
  - the state enum (IDLE, SCAN);
  - function idx_width(WIDTH);
  - function popcount for the remain computation.
- Sub-module lowest_bit_enc (combinational, parameterised by WIDTH):
  - inputs: vec;
  - outputs: idx, found, vecMinusLowest = vec & (vec-1).
- The top level holds pend, the state register and the handshake logic only.

## Test plan

- Reset: hold rst_n=0 with random inputs -> outValid=0, idxOut=0, remain=0, emptyErr=0, inReady=1; after release inReady=1.
- dataIn=8'b1010_0100, polIn=0, outReady=1 -> idxOut 2,5,7 on three consecutive cycles; remain 3,2,1; lastOut only with idx 7; inReady=1 the cycle after.
- dataIn=8'hFE, polIn=1 -> single beat idxOut=0, lastOut=1, remain=1.
- Backpressure with dataIn=8'h81, outReady=0 for 3 cycles -> idxOut=0, remain=2 held stable; then outReady=1 -> idx 0, then idx 7 with lastOut.
- Zero vector: dataIn=8'h00 with polIn=0, then dataIn=8'hFF with polIn=1 -> one emptyErr pulse per capture, outValid never asserted, inReady stays 1.
- Async reset mid-scan: dataIn=8'hFF, assert rst_n=0 after the first beat -> outValid drops without a clock edge; after release no further indices appear and a new vector 8'h10 yields idx 4 with lastOut.

Source files
------------

// File: rtl/encoder83_scan_pkg.sv
`default_nettype none
// =============================================================================
// encoder_pkg : shared types and helpers for the serialising 8-to-3 encoder
// Revision    : 1.0
// =============================================================================
package encoder_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // Widest request vector the popcount helper handles.
    localparam int MAX_WIDTH = 64;
    localparam int MAX_IDX_W = 6;

    function automatic int idx_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    function automatic logic [MAX_IDX_W:0] popcount(input logic [MAX_WIDTH-1:0] vec);
        logic [MAX_IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            cnt = cnt + {{MAX_IDX_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/encoder83_scan_if.sv
`default_nettype none
// =============================================================================
// encoder83_scan_if : request-in / index-out handshake bundle
// Revision          : 1.0
// =============================================================================
interface encoder83_scan_if
    import encoder_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int IDX_W = idx_width(WIDTH);

    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] dataIn;
    logic             polIn;
    logic             outValid;
    logic             outReady;
    logic [IDX_W-1:0] idxOut;
    logic             lastOut;
    logic [IDX_W:0]   remain;
    logic             emptyErr;

    // master: producer of vectors and consumer of indices
    modport master (
        output inValid, dataIn, polIn, outReady,
        input  inReady, outValid, idxOut, lastOut, remain, emptyErr
    );

    modport slave (
        input  inValid, dataIn, polIn, outReady,
        output inReady, outValid, idxOut, lastOut, remain, emptyErr
    );

endinterface
`default_nettype wire

// File: rtl/encoder83_scan_lowest_bit_enc.sv
`default_nettype none
// =============================================================================
// lowest_bit_enc : index of the lowest set bit, plus the vector with it cleared
// Revision       : 1.0
// =============================================================================
module lowest_bit_enc
    import encoder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  wire logic [WIDTH-1:0] vec,
    output logic      [IDX_W-1:0] idx,
    output logic                  found,
    output logic      [WIDTH-1:0] vecMinusLowest
);

    // Scan downward so the lowest set bit is the last to write idx.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign found          = |vec;
    assign vecMinusLowest = vec & (vec - WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/encoder83_scan.sv
`default_nettype none
// =============================================================================
// encoder83_scan : captures a multi-hot/multi-cold vector and emits the index
//                  of every active bit, lowest first, one per output beat
// Revision       : 1.0
// =============================================================================
module encoder83_scan
    import encoder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input wire              clk,
    input wire              rst_n,
    encoder83_scan_if.slave bus
);

    localparam int IDX_W = idx_width(WIDTH);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] pend_d;
    logic             empty_err_q;
    logic             empty_err_d;

    logic [WIDTH-1:0] vec_in;
    logic [IDX_W-1:0] low_idx;
    logic             low_found;
    logic [WIDTH-1:0] pend_cleared;
    logic [IDX_W:0]   remain;
    logic             last;

    lowest_bit_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_lowest_bit_enc (
        .vec            (pend_q),
        .idx            (low_idx),
        .found          (low_found),
        .vecMinusLowest (pend_cleared)
    );

    assign vec_in = bus.polIn ? ~bus.dataIn : bus.dataIn;
    assign remain = (IDX_W + 1)'(popcount(MAX_WIDTH'(pend_q)));
    assign last   = low_found && (remain == (IDX_W + 1)'(1));

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        empty_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.inValid) begin
                    if (vec_in == '0) begin
                        empty_err_d = 1'b1;
                    end else begin
                        pend_d  = vec_in;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (bus.outReady) begin
                    pend_d = pend_cleared;
                    if (last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            empty_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            empty_err_q <= empty_err_d;
        end
    end

    // Outputs come from registers only; pend is zero whenever IDLE.
    assign bus.inReady  = (state_q == ST_IDLE);
    assign bus.outValid = (state_q == ST_SCAN);
    assign bus.idxOut   = low_idx;
    assign bus.lastOut  = last;
    assign bus.remain   = remain;
    assign bus.emptyErr = empty_err_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder83_scan.sv
`default_nettype none
// =============================================================================
// tb_encoder83_scan : directed and randomized checks against a queue model
// Revision          : 1.0
// =============================================================================
module tb_encoder83_scan;
    import encoder_pkg::*;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    encoder83_scan_if #(.WIDTH(WIDTH)) bus ();

    encoder83_scan #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // mode 0: always ready, 1: random ready, 2: stalled for the first 3 cycles
    task automatic send(input logic [WIDTH-1:0] data, input logic pol, input int mode);
        int   exp_q[$];
        int   cyc;
        logic rdy;
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i] != pol) exp_q.push_back(i);
        end
        check("in_ready_pre", 32'(bus.inReady), 32'd1);
        bus.inValid  = 1'b1;
        bus.dataIn   = data;
        bus.polIn    = pol;
        bus.outReady = 1'b0;
        @(posedge clk); #1;
        bus.inValid = 1'b0;
        bus.dataIn  = WIDTH'($urandom);
        bus.polIn   = 1'($urandom);
        if (exp_q.size() == 0) begin
            check("empty_err", 32'(bus.emptyErr), 32'd1);
            check("empty_out_valid", 32'(bus.outValid), 32'd0);
            check("empty_in_ready", 32'(bus.inReady), 32'd1);
            @(posedge clk); #1;
            check("empty_err_pulse", 32'(bus.emptyErr), 32'd0);
            check("empty_out_valid2", 32'(bus.outValid), 32'd0);
            return;
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 64) begin
            check("out_valid", 32'(bus.outValid), 32'd1);
            check("in_ready_busy", 32'(bus.inReady), 32'd0);
            check("idx", 32'(bus.idxOut), exp_q[0]);
            check("remain", 32'(bus.remain), exp_q.size());
            check("last", 32'(bus.lastOut), 32'(exp_q.size() == 1));
            check("no_empty_err", 32'(bus.emptyErr), 32'd0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc >= 3);
            endcase
            bus.outReady = rdy;
            @(posedge clk); #1;
            if (rdy) void'(exp_q.pop_front());
            cyc++;
        end
        check("drain_left", exp_q.size(), 32'd0);
        bus.outReady = 1'b0;
        check("in_ready_after", 32'(bus.inReady), 32'd1);
        check("out_valid_after", 32'(bus.outValid), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic             p;
        rst_n        = 1'b0;
        bus.inValid  = 1'b0;
        bus.dataIn   = '0;
        bus.polIn    = 1'b0;
        bus.outReady = 1'b0;

        // Reset held with random traffic on the inputs
        for (int i = 0; i < 4; i++) begin
            bus.inValid  = 1'($urandom);
            bus.dataIn   = WIDTH'($urandom);
            bus.polIn    = 1'($urandom);
            bus.outReady = 1'($urandom);
            @(posedge clk); #1;
            check("rst_out_valid", 32'(bus.outValid), 32'd0);
            check("rst_idx", 32'(bus.idxOut), 32'd0);
            check("rst_remain", 32'(bus.remain), 32'd0);
            check("rst_last", 32'(bus.lastOut), 32'd0);
            check("rst_empty_err", 32'(bus.emptyErr), 32'd0);
            check("rst_in_ready", 32'(bus.inReady), 32'd1);
        end
        bus.inValid  = 1'b0;
        bus.outReady = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", 32'(bus.inReady), 32'd1);
        check("rel_out_valid", 32'(bus.outValid), 32'd0);

        send(8'b1010_0100, 1'b0, 0);
        send(8'hFE, 1'b1, 0);
        send(8'h81, 1'b0, 2);
        send(8'h00, 1'b0, 0);
        send(8'hFF, 1'b1, 0);

        // Asynchronous reset in the middle of a scan
        check("mid_in_ready", 32'(bus.inReady), 32'd1);
        bus.inValid  = 1'b1;
        bus.dataIn   = 8'hFF;
        bus.polIn    = 1'b0;
        bus.outReady = 1'b1;
        @(posedge clk); #1;
        bus.inValid = 1'b0;
        check("mid_idx0", 32'(bus.idxOut), 32'd0);
        check("mid_remain0", 32'(bus.remain), 32'd8);
        @(posedge clk); #1;
        check("mid_idx1", 32'(bus.idxOut), 32'd1);
        check("mid_remain1", 32'(bus.remain), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(bus.outValid), 32'd0);
        check("async_remain", 32'(bus.remain), 32'd0);
        check("async_idx", 32'(bus.idxOut), 32'd0);
        check("async_in_ready", 32'(bus.inReady), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", 32'(bus.outValid), 32'd0);
        end
        bus.outReady = 1'b0;
        send(8'h10, 1'b0, 0);

        // Randomized vectors with random backpressure; every 8th is empty
        for (int n = 0; n < 40; n++) begin
            p = 1'($urandom);
            d = WIDTH'($urandom);
            if (n % 8 == 7) d = p ? '1 : '0;
            send(d, p, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
